// File: rtl/arbiter_pkg.sv
// Shared FSM encoding and default parameters for the tile write sequencer.
package arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_MAX_WRITES = 32;
  localparam int unsigned DEF_MAX_DEPTH  = 36864;
  localparam int unsigned CNT_WIDTH      = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/tile_write_sequencer_if.sv
// Job configuration, beat handshake and BRAM write bus of the tile write sequencer.
interface tile_write_sequencer_if
  import arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned MAX_WRITES = DEF_MAX_WRITES
);

    logic                            start_job;
    logic [ADDR_WIDTH-1:0]           cfg_base;
    logic [ADDR_WIDTH-1:0]           cfg_stride;
    logic [ADDR_WIDTH-1:0]           cfg_row_pitch;
    logic [$clog2(MAX_WRITES):0]     cfg_writes;
    logic [CNT_WIDTH-1:0]            cfg_tiles_per_row;
    logic [CNT_WIDTH-1:0]            cfg_rows;
    logic [NUM_CH-1:0]               cfg_ch_mask;
    logic                            start_tile;
    logic                            in_valid;
    logic                            abort;
    logic                            in_ready;
    logic [ADDR_WIDTH-1:0]           bram_addr;
    logic [NUM_CH-1:0]               bram_we;
    logic                            tile_done;
    logic                            job_done;
    logic                            addr_err;
    logic                            busy;

    modport master (
        output start_job, cfg_base, cfg_stride, cfg_row_pitch, cfg_writes,
               cfg_tiles_per_row, cfg_rows, cfg_ch_mask, start_tile, in_valid, abort,
        input  in_ready, bram_addr, bram_we, tile_done, job_done, addr_err, busy
    );

    modport slave (
        input  start_job, cfg_base, cfg_stride, cfg_row_pitch, cfg_writes,
               cfg_tiles_per_row, cfg_rows, cfg_ch_mask, start_tile, in_valid, abort,
        output in_ready, bram_addr, bram_we, tile_done, job_done, addr_err, busy
    );

endinterface

// File: rtl/tile_addr_counter.sv
// Beat/tile/row counters with latched job geometry and the resulting BRAM address.
module tile_addr_counter
  import arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_WRITES = DEF_MAX_WRITES,
    localparam int unsigned WW        = $clog2(MAX_WRITES) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [ADDR_WIDTH-1:0] cfg_row_pitch,
    input  logic [WW-1:0]         cfg_writes,
    input  logic [CNT_WIDTH-1:0]  cfg_tiles_per_row,
    input  logic [CNT_WIDTH-1:0]  cfg_rows,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_beat,
    output logic                  final_beat
);

    logic [ADDR_WIDTH-1:0] base_q, stride_q, pitch_q;
    logic [WW-1:0]         writes_q;
    logic [CNT_WIDTH-1:0]  tpr_q, rows_q;
    logic [WW-1:0]         beat_q;
    logic [CNT_WIDTH-1:0]  tile_q, row_q;
    logic                  last_tile;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            pitch_q  <= '0;
            writes_q <= '0;
            tpr_q    <= '0;
            rows_q   <= '0;
            beat_q   <= '0;
            tile_q   <= '0;
            row_q    <= '0;
        end else if (load) begin
            base_q   <= cfg_base;
            stride_q <= cfg_stride;
            pitch_q  <= cfg_row_pitch;
            writes_q <= cfg_writes;
            tpr_q    <= cfg_tiles_per_row;
            rows_q   <= cfg_rows;
            beat_q   <= '0;
            tile_q   <= '0;
            row_q    <= '0;
        end else if (clear) begin
            beat_q <= '0;
            tile_q <= '0;
            row_q  <= '0;
        end else if (advance) begin
            if (last_beat) begin
                beat_q <= '0;
                if (last_tile) begin
                    tile_q <= '0;
                    row_q  <= row_q + CNT_WIDTH'(1);
                end else begin
                    tile_q <= tile_q + CNT_WIDTH'(1);
                end
            end else begin
                beat_q <= beat_q + WW'(1);
            end
        end
    end

    always_comb begin
        last_beat  = (beat_q == writes_q - WW'(1));
        last_tile  = (tile_q == tpr_q - CNT_WIDTH'(1));
        final_beat = last_beat && last_tile && (row_q == rows_q - CNT_WIDTH'(1));
        // Tile index is a unit column offset within the row; products wrap to ADDR_WIDTH.
        addr = base_q + ADDR_WIDTH'(row_q) * pitch_q + ADDR_WIDTH'(tile_q)
             + ADDR_WIDTH'(beat_q) * stride_q;
    end

endmodule

// File: rtl/tile_write_sequencer.sv
// Sequences systolic-array output beats into multi-channel BRAM writes, tile by tile.
module tile_write_sequencer
  import arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned MAX_WRITES = DEF_MAX_WRITES,
    parameter int unsigned MAX_DEPTH  = DEF_MAX_DEPTH
) (
    input logic                   clk,
    input logic                   rst_n,
    tile_write_sequencer_if.slave bus
);

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     mask_q;
    logic                  tile_done_q;
    logic                  addr_err_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last_beat, final_beat;
    logic                  load, beat_fire, out_of_range;

    assign load         = (state_q == StIdle) && bus.start_job && !bus.abort;
    assign beat_fire    = (state_q == StWrite) && bus.in_valid && !bus.abort;
    assign out_of_range = 32'(addr) >= MAX_DEPTH;

    tile_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_WRITES (MAX_WRITES)
    ) u_counter (
        .clk               (clk),
        .rst_n             (rst_n),
        .load              (load),
        .clear             (bus.abort),
        .advance           (beat_fire),
        .cfg_base          (bus.cfg_base),
        .cfg_stride        (bus.cfg_stride),
        .cfg_row_pitch     (bus.cfg_row_pitch),
        .cfg_writes        (bus.cfg_writes),
        .cfg_tiles_per_row (bus.cfg_tiles_per_row),
        .cfg_rows          (bus.cfg_rows),
        .addr              (addr),
        .last_beat         (last_beat),
        .final_beat        (final_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (bus.start_job) state_d = StArmed;
                StArmed: if (bus.start_tile) state_d = StWrite;
                StWrite: if (bus.in_valid && last_beat) state_d = final_beat ? StDone : StArmed;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            tile_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            tile_done_q <= beat_fire && last_beat && !final_beat;
            if (load) begin
                mask_q     <= bus.cfg_ch_mask;
                addr_err_q <= 1'b0;
            end else if (beat_fire && out_of_range) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StWrite);
        bus.busy      = (state_q != StIdle);
        bus.bram_addr = addr;
        bus.bram_we   = (beat_fire && !out_of_range) ? mask_q : '0;
        bus.tile_done = tile_done_q && !bus.abort;
        bus.job_done  = (state_q == StDone) && !bus.abort;
        bus.addr_err  = addr_err_q;
    end

endmodule
